// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
//
// Execute-stage ALU with a valid/ready request side and a valid/ready result
// side. Add, sub, AND, OR and signed set-less-than complete in one cycle.
// Multiply is a WIDTH-step shift-add sequence that keeps the low WIDTH bits of
// the unsigned product.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      request present
//   in_ready   out  1      request can be accepted this cycle
//   alu_ctrl   in   3      op code: 000 add, 001 sub, 010 and, 011 or,
//                          100 slt (signed), 101 mul, 110/111 illegal
//   src_a      in   WIDTH  operand A
//   src_b      in   WIDTH  operand B
//   out_valid  out  1      result registers hold an unconsumed result
//   out_ready  in   1      consumer takes the result this cycle
//   result     out  WIDTH  registered result
//   zero       out  1      registered result == 0
//   overflow   out  1      registered signed overflow (add/sub only)
//   illegal    out  1      registered illegal op code flag
//   busy       out  1      multiply in progress
// -----------------------------------------------------------------------------
module alu_exec_unit #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal,
    output logic             busy
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastStep = CntW'(WIDTH - 1);

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOr  = 3'b011;
    localparam logic [2:0] OpSlt = 3'b100;
    localparam logic [2:0] OpMul = 3'b101;

    typedef enum logic [0:0] {
        StIdle,
        StMul
    } state_e;

    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             overflow_q, overflow_d;
    logic             illegal_q, illegal_d;

    // Multiply datapath: accumulator, shifting multiplicand/multiplier, step count.
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic accept;
    logic consume;

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    assign in_ready = (state_q == StIdle) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid_q && out_ready;

    // -------------------------------------------------------------------------
    // Single-cycle datapath, evaluated on the live inputs at the accepting edge
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             add_ovf;
    logic             sub_ovf;
    logic             slt;

    assign sum  = src_a + src_b;
    assign diff = src_a - src_b;

    // Add overflows when both operands share a sign that the sum does not.
    assign add_ovf = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);
    // Sub overflows when operand signs differ and the difference flips A's sign.
    assign sub_ovf = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (diff[WIDTH-1] != src_a[WIDTH-1]);
    assign slt     = $signed(src_a) < $signed(src_b);

    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic             alu_ill;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (alu_ctrl)
            OpAdd: begin
                alu_res = sum;
                alu_ovf = add_ovf;
            end
            OpSub: begin
                alu_res = diff;
                alu_ovf = sub_ovf;
            end
            OpAnd: alu_res = src_a & src_b;
            OpOr:  alu_res = src_a | src_b;
            OpSlt: alu_res[0] = slt;
            OpMul: alu_res = '0;  // handled by the multiply sequence
            default: begin
                alu_res = '0;
                alu_ill = 1'b1;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Multiply step: add the multiplicand when the current multiplier LSB is set
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] step_acc;

    assign step_acc = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        overflow_d  = overflow_q;
        illegal_d   = illegal_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        cnt_d       = cnt_q;

        if (consume) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (alu_ctrl == OpMul) begin
                        state_d  = StMul;
                        acc_d    = '0;
                        mcand_d  = src_a;
                        mplier_d = src_b;
                        cnt_d    = '0;
                    end else begin
                        result_d    = alu_res;
                        zero_d      = (alu_res == '0);
                        overflow_d  = alu_ovf;
                        illegal_d   = alu_ill;
                        out_valid_d = 1'b1;
                    end
                end
            end

            StMul: begin
                acc_d    = step_acc;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CntW'(1);
                // The final step's sum goes straight to the result registers so
                // out_valid rises exactly WIDTH edges after the accept.
                if (cnt_q == LastStep) begin
                    result_d    = step_acc;
                    zero_d      = (step_acc == '0);
                    overflow_d  = 1'b0;
                    illegal_d   = 1'b0;
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
            illegal_q   <= 1'b0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            overflow_q  <= overflow_d;
            illegal_q   <= illegal_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign overflow  = overflow_q;
    assign illegal   = illegal_q;
    assign busy      = (state_q == StMul);

endmodule
